// File: rtl/csr_trap_ctrl_if.sv
// rtl/csr_trap_ctrl_if.sv - retirement/CSR bundle between the pipeline and the trap sequencer
//
// Purpose: groups the retirement flags, the CSR values and the trap sequencer
//          outputs into one bundle.
// Modports:
//   master - pipeline/CSR side: drives valid_i, illegal_i, ecall_i, ebreak_i,
//            mret_i, pc_i, mtvec_i and mepc_i, and receives the sequencer outputs.
//   slave  - csr_trap_ctrl side: the same signals in the opposite direction.
// Optional: trap_count_o exists only when CSR_TRAP_COUNT_EN is defined.

interface csr_trap_ctrl_if;
  logic        valid_i;
  logic        illegal_i;
  logic        ecall_i;
  logic        ebreak_i;
  logic        mret_i;
  logic [31:0] pc_i;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;
  logic [1:0]  exception_o;
  logic        mepc_we_o;
  logic [31:0] mepc_o;
  logic        stall_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        trap_enter_o;
  logic        trap_exit_o;
`ifdef CSR_TRAP_COUNT_EN
  logic [31:0] trap_count_o;
`endif

  modport master (
    output valid_i, illegal_i, ecall_i, ebreak_i, mret_i, pc_i, mtvec_i, mepc_i,
    input  exception_o, mepc_we_o, mepc_o, stall_o, redirect_o, redirect_pc_o,
    input  trap_enter_o, trap_exit_o
`ifdef CSR_TRAP_COUNT_EN
    , input trap_count_o
`endif
  );

  modport slave (
    input  valid_i, illegal_i, ecall_i, ebreak_i, mret_i, pc_i, mtvec_i, mepc_i,
    output exception_o, mepc_we_o, mepc_o, stall_o, redirect_o, redirect_pc_o,
    output trap_enter_o, trap_exit_o
`ifdef CSR_TRAP_COUNT_EN
    , output trap_count_o
`endif
  );
endinterface

// File: rtl/csr_trap_ctrl.sv
// rtl/csr_trap_ctrl.sv - trap entry/return sequencer feeding mcause/mepc and the PC redirect
//
// Purpose: samples exception flags and mret of the retiring instruction, stalls
//          the pipeline while mcause/mepc are updated and the pipe is flushed,
//          then redirects the PC to mtvec (trap) or mepc (mret).
// Parameters:
//   FLUSH_CYCLES - stall cycles between the mcause/mepc update and the redirect (0..15).
// Ports:
//   clk_i - clock
//   rst_i - synchronous active-high reset
//   bus   - csr_trap_ctrl_if.slave: retirement flags, pc/mtvec/mepc in;
//           exception code, mepc write, stall, redirect, mstatus pulses out.
// Optional: define CSR_TRAP_COUNT_EN to add the wrapping 32-bit trap counter
//           (bus.trap_count_o).

module csr_trap_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  csr_trap_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRAP,
    ST_FLUSH,
    ST_REDIRECT,
    ST_RET
  } state_t;

  // Counter value loaded on entry to FLUSH; FLUSH is skipped when the window is 0.
  localparam logic [3:0] LP_FLUSH_LOAD = (FLUSH_CYCLES == 0) ? 4'd0 : 4'(FLUSH_CYCLES - 1);
  localparam logic       LP_NO_FLUSH   = (FLUSH_CYCLES == 0);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [1:0]  r_code;
  logic [31:2] r_pc;
  logic        r_mepc_we;
  logic        r_stall;
  logic        r_redirect;
  logic        r_trap_enter;
  logic        r_trap_exit;

  logic        w_any_exc;
  logic [1:0]  w_code;

  assign w_any_exc = bus.illegal_i | bus.ecall_i | bus.ebreak_i;

  // illegal > ebreak > ecall
  always_comb begin
    w_code = 2'b00;
    if (bus.illegal_i) begin
      w_code = 2'b01;
    end else if (bus.ebreak_i) begin
      w_code = 2'b11;
    end else if (bus.ecall_i) begin
      w_code = 2'b10;
    end
  end

  // Strobe outputs are registered alongside the state, so each one is high
  // exactly while the FSM sits in the state that owns it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_code       <= 2'b00;
      r_pc         <= 30'd0;
      r_mepc_we    <= 1'b0;
      r_stall      <= 1'b0;
      r_redirect   <= 1'b0;
      r_trap_enter <= 1'b0;
      r_trap_exit  <= 1'b0;
    end else begin
      r_mepc_we    <= 1'b0;
      r_stall      <= 1'b0;
      r_redirect   <= 1'b0;
      r_trap_enter <= 1'b0;
      r_trap_exit  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.valid_i) begin
            if (w_any_exc) begin
              // An exception always beats a simultaneous mret.
              r_code       <= w_code;
              r_pc         <= bus.pc_i[31:2];
              r_state      <= ST_TRAP;
              r_mepc_we    <= 1'b1;
              r_trap_enter <= 1'b1;
              r_stall      <= 1'b1;
            end else if (bus.mret_i) begin
              r_state      <= ST_RET;
              r_redirect   <= 1'b1;
              r_trap_exit  <= 1'b1;
              r_stall      <= 1'b1;
            end
          end
        end
        ST_TRAP: begin
          r_stall <= 1'b1;
          if (LP_NO_FLUSH) begin
            r_state    <= ST_REDIRECT;
            r_redirect <= 1'b1;
          end else begin
            r_state <= ST_FLUSH;
            r_cnt   <= LP_FLUSH_LOAD;
          end
        end
        ST_FLUSH: begin
          r_stall <= 1'b1;
          if (r_cnt == 4'd0) begin
            r_state    <= ST_REDIRECT;
            r_redirect <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_REDIRECT: r_state <= ST_IDLE;
        ST_RET:      r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  // Code and PC are held in latches that only change on trap entry, so
  // decoding them with the TRAP state keeps these outputs registered.
  assign bus.exception_o  = (r_state == ST_TRAP) ? r_code : 2'b00;
  assign bus.mepc_o       = (r_state == ST_TRAP) ? {r_pc, 2'b00} : 32'd0;
  assign bus.mepc_we_o    = r_mepc_we;
  assign bus.stall_o      = r_stall;
  assign bus.redirect_o   = r_redirect;
  assign bus.trap_enter_o = r_trap_enter;
  assign bus.trap_exit_o  = r_trap_exit;

  // Targets are read live in the redirect cycle so a mepc write that lands
  // just before mret is honoured.
  always_comb begin
    bus.redirect_pc_o = 32'd0;
    if (r_state == ST_REDIRECT) begin
      bus.redirect_pc_o = {bus.mtvec_i[31:2], 2'b00};
    end else if (r_state == ST_RET) begin
      bus.redirect_pc_o = {bus.mepc_i[31:2], 2'b00};
    end
  end

`ifdef CSR_TRAP_COUNT_EN
  logic [31:0] r_trap_count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_trap_count <= 32'd0;
    end else if (r_state == ST_TRAP) begin
      r_trap_count <= r_trap_count + 32'd1;
    end
  end

  assign bus.trap_count_o = r_trap_count;
`endif

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb/tb_csr_trap_ctrl.sv - directed self-checking bench for csr_trap_ctrl

module tb_csr_trap_ctrl;

  logic clk;
  logic rst2;
  logic rst0;
  logic rst5;
  int   n_assert;
  int   n_fail;

  csr_trap_ctrl_if b2 ();
  csr_trap_ctrl_if b0 ();
  csr_trap_ctrl_if b5 ();

  csr_trap_ctrl #(.FLUSH_CYCLES(2)) u_dut2 (.clk_i(clk), .rst_i(rst2), .bus(b2));
  csr_trap_ctrl #(.FLUSH_CYCLES(0)) u_dut0 (.clk_i(clk), .rst_i(rst0), .bus(b0));
  csr_trap_ctrl #(.FLUSH_CYCLES(5)) u_dut5 (.clk_i(clk), .rst_i(rst5), .bus(b5));

  always #5 clk = ~clk;

  // Flag vector order: {exception[1:0], mepc_we, stall, redirect, trap_enter, trap_exit}
  localparam logic [6:0] F_IDLE   = 7'b00_0_0_0_0_0;
  localparam logic [6:0] F_FLUSH  = 7'b00_0_1_0_0_0;
  localparam logic [6:0] F_REDIR  = 7'b00_0_1_1_0_0;
  localparam logic [6:0] F_RET    = 7'b00_0_1_1_0_1;
  localparam logic [6:0] F_T_ILL  = 7'b01_1_1_0_1_0;
  localparam logic [6:0] F_T_ECL  = 7'b10_1_1_0_1_0;
  localparam logic [6:0] F_T_EBK  = 7'b11_1_1_0_1_0;

  function automatic logic [31:0] fl2();
    return {25'd0, b2.exception_o, b2.mepc_we_o, b2.stall_o, b2.redirect_o, b2.trap_enter_o, b2.trap_exit_o};
  endfunction
  function automatic logic [31:0] fl0();
    return {25'd0, b0.exception_o, b0.mepc_we_o, b0.stall_o, b0.redirect_o, b0.trap_enter_o, b0.trap_exit_o};
  endfunction
  function automatic logic [31:0] fl5();
    return {25'd0, b5.exception_o, b5.mepc_we_o, b5.stall_o, b5.redirect_o, b5.trap_enter_o, b5.trap_exit_o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    b2.valid_i = 0; b2.illegal_i = 0; b2.ecall_i = 0; b2.ebreak_i = 0; b2.mret_i = 0;
    b0.valid_i = 0; b0.illegal_i = 0; b0.ecall_i = 0; b0.ebreak_i = 0; b0.mret_i = 0;
    b5.valid_i = 0; b5.illegal_i = 0; b5.ecall_i = 0; b5.ebreak_i = 0; b5.mret_i = 0;
  endtask

  // Presents one retiring instruction on dut2 for one cycle; returns in the
  // cycle after the sampling edge.
  task automatic issue2(input logic il, input logic ec, input logic eb, input logic mr,
                        input logic [31:0] pc);
    b2.valid_i = 1; b2.illegal_i = il; b2.ecall_i = ec; b2.ebreak_i = eb; b2.mret_i = mr;
    b2.pc_i = pc;
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    clk  = 0;
    rst2 = 1; rst0 = 1; rst5 = 1;
    clear_inputs();
    b2.pc_i = 0; b2.mtvec_i = 0; b2.mepc_i = 0;
    b0.pc_i = 0; b0.mtvec_i = 0; b0.mepc_i = 0;
    b5.pc_i = 0; b5.mtvec_i = 0; b5.mepc_i = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_flags", fl2(), {25'd0, F_IDLE});
    chk("rst_mepc", b2.mepc_o, 32'd0);
    chk("rst_rpc", b2.redirect_pc_o, 32'd0);
    rst2 = 0; rst0 = 0; rst5 = 0;

    // Idle with valid_i=0 while flags toggle: nothing may happen
    b2.mtvec_i = 32'h0000_0200;
    for (int i = 0; i < 10; i++) begin
      b2.illegal_i = i[0]; b2.ecall_i = i[1]; b2.ebreak_i = i[2]; b2.mret_i = ~i[0];
      b2.pc_i = 32'(i * 4);
      @(negedge clk);
      chk("idle_flags", fl2(), {25'd0, F_IDLE});
      chk("idle_rpc", b2.redirect_pc_o, 32'd0);
    end
    clear_inputs();
    @(negedge clk);

    // Illegal trap, FLUSH_CYCLES=2; valid+mret held during flush must be ignored
    b2.valid_i = 1; b2.illegal_i = 1; b2.pc_i = 32'h0000_0104;
    @(negedge clk);
    chk("ill_trap", fl2(), {25'd0, F_T_ILL});
    chk("ill_mepc", b2.mepc_o, 32'h0000_0104);
    b2.illegal_i = 0; b2.mret_i = 1;
    @(negedge clk);
    chk("ill_flush1", fl2(), {25'd0, F_FLUSH});
    chk("ill_flush1_mepc", b2.mepc_o, 32'd0);
    @(negedge clk);
    chk("ill_flush2", fl2(), {25'd0, F_FLUSH});
    clear_inputs();
    @(negedge clk);
    chk("ill_redir", fl2(), {25'd0, F_REDIR});
    chk("ill_redir_pc", b2.redirect_pc_o, 32'h0000_0200);
    @(negedge clk);
    chk("ill_done", fl2(), {25'd0, F_IDLE});

    // ecall+ebreak+mret: ebreak wins, no trap_exit anywhere in the sequence
    issue2(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0042);
    chk("ebk_trap", fl2(), {25'd0, F_T_EBK});
    chk("ebk_mepc", b2.mepc_o, 32'h0000_0040);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("ebk_no_exit", {31'd0, b2.trap_exit_o}, 32'd0);
    end
    @(negedge clk);
    chk("ebk_done", fl2(), {25'd0, F_IDLE});

    // Same with illegal also set: illegal wins
    issue2(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0080);
    chk("all_trap", fl2(), {25'd0, F_T_ILL});
    repeat (4) @(negedge clk);
    chk("all_done", fl2(), {25'd0, F_IDLE});

    // mret: one RET cycle; an ecall held through RET is only taken in the next IDLE cycle
    b2.mepc_i = 32'h0000_0356;
    issue2(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0300);
    chk("ret_flags", fl2(), {25'd0, F_RET});
    chk("ret_pc", b2.redirect_pc_o, 32'h0000_0354);
    b2.valid_i = 1; b2.ecall_i = 1; b2.pc_i = 32'h0000_0500;
    @(negedge clk);
    chk("ret_idle", fl2(), {25'd0, F_IDLE});
    @(negedge clk);
    clear_inputs();
    chk("b2b_trap", fl2(), {25'd0, F_T_ECL});
    chk("b2b_mepc", b2.mepc_o, 32'h0000_0500);
    repeat (4) @(negedge clk);
    chk("b2b_done", fl2(), {25'd0, F_IDLE});

    // FLUSH_CYCLES=0: TRAP then REDIRECT directly
    b0.mtvec_i = 32'h8000_0003;
    b0.valid_i = 1; b0.ecall_i = 1; b0.pc_i = 32'h0000_0010;
    @(negedge clk);
    clear_inputs();
    chk("f0_trap", fl0(), {25'd0, F_T_ECL});
    chk("f0_mepc", b0.mepc_o, 32'h0000_0010);
    @(negedge clk);
    chk("f0_redir", fl0(), {25'd0, F_REDIR});
    chk("f0_redir_pc", b0.redirect_pc_o, 32'h8000_0000);
    @(negedge clk);
    chk("f0_done", fl0(), {25'd0, F_IDLE});

    // FLUSH_CYCLES=5: reset during FLUSH aborts, no redirect follows
    b5.mtvec_i = 32'h0000_0400;
    b5.valid_i = 1; b5.ebreak_i = 1; b5.pc_i = 32'h0000_0020;
    @(negedge clk);
    clear_inputs();
    chk("f5_trap", fl5(), {25'd0, F_T_EBK});
    @(negedge clk);
    chk("f5_flush", fl5(), {25'd0, F_FLUSH});
    @(negedge clk);
    rst5 = 1;
    @(negedge clk);
    chk("f5_rst_flags", fl5(), {25'd0, F_IDLE});
    chk("f5_rst_mepc", b5.mepc_o, 32'd0);
    chk("f5_rst_rpc", b5.redirect_pc_o, 32'd0);
    rst5 = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("f5_no_redir", fl5(), {25'd0, F_IDLE});
    end

`ifdef CSR_TRAP_COUNT_EN
    rst2 = 1;
    @(negedge clk);
    rst2 = 0;
    chk("cnt_rst", b2.trap_count_o, 32'd0);
    for (int t = 0; t < 3; t++) begin
      issue2(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0004);
      repeat (4) @(negedge clk);
      issue2(1'b0, 1'b0, 1'b0, t < 2, 32'h0000_0008);
      @(negedge clk);
    end
    chk("cnt_three", b2.trap_count_o, 32'd3);
    force u_dut2.r_trap_count = 32'hFFFF_FFFF;
    #1;
    release u_dut2.r_trap_count;
    issue2(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_000C);
    repeat (4) @(negedge clk);
    chk("cnt_wrap", b2.trap_count_o, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_trap_ctrl.md
# csr_trap_ctrl

Trap sequencer in the CSR unit, directly upstream of the mcause register. Samples per-instruction exception flags and `mret` at retirement, then stalls the pipeline for a fixed flush window. During that window it drives the 2-bit exception code consumed by mcause and writes mepc. It finishes with a PC redirect to mtvec on a trap, or to mepc on `mret`.

## Interface
Parameters:
- FLUSH_CYCLES, 2, stall cycles between the mcause/mepc update and the redirect; legal range 0..15.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-high reset.
- valid_i  input  1  an instruction is retiring this cycle.
- illegal_i  input  1  the retiring instruction is illegal.
- ecall_i  input  1  the retiring instruction is ECALL.
- ebreak_i  input  1  the retiring instruction is EBREAK.
- mret_i  input  1  the retiring instruction is MRET.
- pc_i  input  32  PC of the retiring instruction.
- mtvec_i  input  32  current mtvec value.
- mepc_i  input  32  current mepc value.
- exception_o  output  2  code to mcause: 00 none, 01 illegal, 10 ecall, 11 ebreak.
- mepc_we_o  output  1  mepc write strobe.
- mepc_o  output  32  mepc write data.
- stall_o  output  1  freeze fetch/decode/retire.
- redirect_o  output  1  one-cycle PC redirect strobe.
- redirect_pc_o  output  32  redirect target.
- trap_enter_o  output  1  pulse to mstatus (MPIE<=MIE, MIE<=0).
- trap_exit_o  output  1  pulse to mstatus (MIE<=MPIE).

## Operation
- States: IDLE, TRAP, FLUSH, REDIRECT, RET.
- IDLE: inputs are sampled only when valid_i=1.
  - Any exception flag set: latch the code and pc_i, then go to TRAP.
  - Priority among exception flags: illegal > ebreak > ecall.
  - Otherwise, if mret_i=1: go to RET.
  - If an exception flag and mret_i are both set, the exception wins.
- TRAP (1 cycle):
  - exception_o = latched code.
  - mepc_we_o=1, with mepc_o = {latched_pc[31:2],2'b00}.
  - trap_enter_o=1.
  - Next state is FLUSH, or REDIRECT if FLUSH_CYCLES=0.
- FLUSH: a 4-bit counter loads FLUSH_CYCLES-1 on entry and decrements each cycle; at 0 go to REDIRECT.
- REDIRECT (1 cycle): redirect_o=1, redirect_pc_o={mtvec_i[31:2],2'b00}; next state IDLE.
- RET (1 cycle): redirect_o=1, redirect_pc_o={mepc_i[31:2],2'b00}, trap_exit_o=1; next state IDLE.
- stall_o=1 in TRAP, FLUSH, REDIRECT and RET; stall_o=0 in IDLE.
- All inputs are ignored outside IDLE. Flags presented then are dropped; the pipeline is stalled, so none are expected.
- mtvec_i and mepc_i are sampled combinationally in the redirect cycle. mepc_i therefore reflects any write completed before that cycle.
- exception_o, mepc_we_o, redirect_o, trap_enter_o and trap_exit_o are 0 in every state except as listed above.

## Timing
- Reset values: state IDLE, counter 0, latched code 00, latched pc 0. All outputs 0, with redirect_pc_o and mepc_o = 0.
- Reset asserted mid-sequence aborts it: IDLE on the next edge, no redirect issued.
- Exception sampled at edge N:
  - TRAP is active during cycle N+1; mcause and mepc capture at edge N+2.
  - REDIRECT is active during cycle N+2+FLUSH_CYCLES.
  - Total stall is FLUSH_CYCLES+2 cycles.
- mret sampled at edge N: RET is active during cycle N+1; stall is 1 cycle.
- A new instruction can be accepted in the cycle immediately after REDIRECT or RET.
- All outputs are registered-state decodes: no combinational path from valid_i or the flag inputs to any output.

## Configuration
- CSR_TRAP_COUNT_EN defined:
  - Adds output trap_count_o [31:0], reset 0.
  - Increments by 1 on each TRAP cycle and wraps from 0xFFFFFFFF to 0.
  - mret does not count.
- CSR_TRAP_COUNT_EN undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, then idle: all outputs 0 and stall_o=0 for 10 cycles with valid_i=0, even when flags are toggled.
- illegal_i, pc_i=0x00000104, mtvec_i=0x00000200, FLUSH_CYCLES=2:
  - Next cycle: exception_o=01, mepc_we_o=1, mepc_o=0x104, trap_enter_o=1.
  - 3 cycles after TRAP: redirect_o=1, redirect_pc_o=0x200.
  - stall_o high for 4 cycles.
- Simultaneous ecall_i+ebreak_i+mret_i: exception_o=11, trap_exit_o never asserts. Repeat with illegal_i also set: exception_o=01.
- mret_i with mepc_i=0x00000356: one cycle with redirect_o=1, redirect_pc_o=0x354, trap_exit_o=1, stall_o=1; IDLE next.
- FLUSH_CYCLES=0, ecall_i: TRAP (exception_o=10) followed immediately by REDIRECT; stall 2 cycles. rst_i asserted during FLUSH (FLUSH_CYCLES=5): no redirect_o, all outputs 0 after the edge.
- CSR_TRAP_COUNT_EN: after 3 traps and 2 mrets, trap_count_o=3. Preloading via force to 0xFFFFFFFF then one trap gives 0.
